sha256_feeder: RTL and testbench

SHA256_FEEDER -- requirements
Module: sha256_feeder

---
 rtl/sha256_feeder.sv | 188 ++++++++++++++++++
 tb/tb_sha256_feeder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_feeder.sv
// Packs a big-endian 32-bit word stream into 512-bit SHA-256 blocks, applies
// message padding and the 64-bit length, and sequences the hash core per block.
module sha256_feeder #(
   parameter int unsigned BlockWidth = 512
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [31:0]           s_data_i,
   input  logic                  s_valid_i,
   input  logic                  s_last_i,
   input  logic [1:0]            s_bytes_i,
   output logic                  s_ready_o,
   input  logic                  clear_i,
   output logic [BlockWidth-1:0] blk_o,
   output logic                  core_en_o,
   output logic                  core_rst_o,
   input  logic                  core_hold_i,
   input  logic                  core_valid_i,
   output logic                  busy_o,
   output logic                  done_o
);

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      PAD,
      LAUNCH,
      RUN,
      DONE
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] buf_q [16];
   logic [31:0] buf_d [16];
   logic [4:0]  widx_q, widx_d;
   logic [63:0] bitcnt_q, bitcnt_d;
   logic        pad_pending_q, pad_pending_d;
   logic        final_q, final_d;
   logic        lenonly_q, lenonly_d;

   logic [31:0] word;
   logic [4:0]  pidx;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         for (int unsigned i = 0; i < 16; i++) begin
            buf_q[i] <= '0;
         end
         widx_q        <= '0;
         bitcnt_q      <= '0;
         pad_pending_q <= 1'b0;
         final_q       <= 1'b0;
         lenonly_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         buf_q         <= buf_d;
         widx_q        <= widx_d;
         bitcnt_q      <= bitcnt_d;
         pad_pending_q <= pad_pending_d;
         final_q       <= final_d;
         lenonly_q     <= lenonly_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      buf_d         = buf_q;
      widx_d        = widx_q;
      bitcnt_d      = bitcnt_q;
      pad_pending_d = pad_pending_q;
      final_d       = final_q;
      lenonly_d     = lenonly_q;
      s_ready_o     = 1'b0;
      core_en_o     = 1'b0;
      core_rst_o    = 1'b0;
      word          = s_data_i;
      pidx          = '0;

      case (state_q)
         IDLE: begin
            core_rst_o = 1'b1;
            for (int unsigned i = 0; i < 16; i++) begin
               buf_d[i[3:0]] = '0;
            end
            widx_d        = '0;
            bitcnt_d      = '0;
            pad_pending_d = 1'b0;
            final_d       = 1'b0;
            lenonly_d     = 1'b0;
            if (s_valid_i) begin
               state_d = FILL;
            end
         end

         FILL: begin
            s_ready_o = 1'b1;
            if (s_valid_i) begin
               // Partial last word carries the 0x80 marker right after its valid bytes.
               if (s_last_i) begin
                  case (s_bytes_i)
                     2'd1:    word = {s_data_i[31:24], 8'h80, 16'h0000};
                     2'd2:    word = {s_data_i[31:16], 8'h80, 8'h00};
                     2'd3:    word = {s_data_i[31:8], 8'h80};
                     default: word = s_data_i;
                  endcase
               end
               buf_d[widx_q[3:0]] = word;
               widx_d             = widx_q + 5'd1;
               if (s_last_i && (s_bytes_i != 2'd0)) begin
                  bitcnt_d = bitcnt_q + {59'b0, s_bytes_i, 3'b000};
               end else begin
                  bitcnt_d = bitcnt_q + 64'd32;
               end
               if (s_last_i) begin
                  pad_pending_d = (s_bytes_i == 2'd0);
                  state_d       = PAD;
               end else if (widx_q == 5'd15) begin
                  state_d = LAUNCH;
               end
            end
         end

         PAD: begin
            if (lenonly_q) begin
               buf_d[14]  = bitcnt_q[63:32];
               buf_d[15]  = bitcnt_q[31:0];
               final_d    = 1'b1;
               lenonly_d  = 1'b0;
            end else begin
               // pidx is the word holding the 0x80 marker; 16 means it spills into a second block.
               pidx = pad_pending_q ? widx_q : (widx_q - 5'd1);
               for (int unsigned i = 0; i < 16; i++) begin
                  if (i > {27'b0, pidx}) begin
                     buf_d[i[3:0]] = '0;
                  end
               end
               if (pad_pending_q && !widx_q[4]) begin
                  buf_d[widx_q[3:0]] = 32'h8000_0000;
               end
               if (pidx <= 5'd13) begin
                  buf_d[14] = bitcnt_q[63:32];
                  buf_d[15] = bitcnt_q[31:0];
                  final_d   = 1'b1;
               end
               lenonly_d     = (pidx == 5'd14) || (pidx == 5'd15);
               pad_pending_d = pidx[4];
            end
            state_d = LAUNCH;
         end

         LAUNCH: begin
            core_en_o = 1'b1;
            state_d   = RUN;
         end

         RUN: begin
            core_en_o = ~core_hold_i;
            if (final_q && (core_valid_i || core_hold_i)) begin
               state_d = DONE;
            end else if (core_hold_i) begin
               for (int unsigned i = 0; i < 16; i++) begin
                  buf_d[i[3:0]] = '0;
               end
               widx_d  = '0;
               state_d = (pad_pending_q || lenonly_q) ? PAD : FILL;
            end
         end

         DONE: begin
            if (clear_i) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign blk_o = {buf_q[0],  buf_q[1],  buf_q[2],  buf_q[3],
                   buf_q[4],  buf_q[5],  buf_q[6],  buf_q[7],
                   buf_q[8],  buf_q[9],  buf_q[10], buf_q[11],
                   buf_q[12], buf_q[13], buf_q[14], buf_q[15]};

   assign busy_o = (state_q != IDLE) && (state_q != DONE);
   assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_sha256_feeder.sv
// Directed self-checking bench for sha256_feeder: padding/length layouts,
// launch counts, backpressure, clear and mid-run reset.
module tb_sha256_feeder;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic [31:0]  s_data_i = '0;
   logic         s_valid_i = 1'b0;
   logic         s_last_i = 1'b0;
   logic [1:0]   s_bytes_i = '0;
   logic         s_ready_o;
   logic         clear_i = 1'b0;
   logic [511:0] blk_o;
   logic         core_en_o;
   logic         core_rst_o;
   logic         core_hold_i = 1'b0;
   logic         core_valid_i = 1'b0;
   logic         busy_o;
   logic         done_o;

   int checks = 0;
   int errors = 0;

   sha256_feeder #(.BlockWidth(512)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .s_data_i     (s_data_i),
      .s_valid_i    (s_valid_i),
      .s_last_i     (s_last_i),
      .s_bytes_i    (s_bytes_i),
      .s_ready_o    (s_ready_o),
      .clear_i      (clear_i),
      .blk_o        (blk_o),
      .core_en_o    (core_en_o),
      .core_rst_o   (core_rst_o),
      .core_hold_i  (core_hold_i),
      .core_valid_i (core_valid_i),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   always #5 clk_i = ~clk_i;

   // Launch monitor: records blk_o at every rising edge of core_en_o.
   int           launches = 0;
   logic [511:0] cap [16];
   logic         en_prev = 1'b0;

   always @(negedge clk_i) begin
      #3;
      if (core_en_o && !en_prev) begin
         cap[launches[3:0]] = blk_o;
         launches++;
      end
      en_prev = core_en_o;
   end

   initial begin
      #300000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] put(input logic [511:0] b, input int unsigned i,
                                        input logic [31:0] v);
      return b | ({480'b0, v} << (32 * (15 - i)));
   endfunction

   function automatic logic [31:0] w(input int unsigned i);
      return 32'hC0DE_0000 | i;
   endfunction

   function automatic logic [511:0] capat(input int k);
      return cap[k[3:0]];
   endfunction

   task automatic send(input logic [31:0] d, input logic l, input logic [1:0] b);
      int n;
      n         = 0;
      s_data_i  = d;
      s_valid_i = 1'b1;
      s_last_i  = l;
      s_bytes_i = b;
      while (!s_ready_o && n < 40) begin
         @(negedge clk_i);
         n++;
      end
      if (!s_ready_o) begin
         checks++;
         errors++;
         $error("FAIL send_timeout observed=ready0 expected=ready1");
      end
      @(negedge clk_i);
      s_valid_i = 1'b0;
      s_last_i  = 1'b0;
      s_bytes_i = '0;
   endtask

   task automatic wait_en();
      int n;
      n = 0;
      while (!core_en_o && n < 40) begin
         @(negedge clk_i);
         n++;
      end
      if (!core_en_o) begin
         checks++;
         errors++;
         $error("FAIL launch_timeout observed=en0 expected=en1");
      end
   endtask

   task automatic run_core();
      logic [511:0] b;
      wait_en();
      chk("ready_launch", 32'(s_ready_o), 0);
      b = blk_o;
      repeat (2) @(negedge clk_i);
      chkb("blk_stable", blk_o, b);
      chk("ready_run", 32'(s_ready_o), 0);
      chk("en_run", 32'(core_en_o), 1);
      core_hold_i = 1'b1;
      #1;
      chk("en_drop", 32'(core_en_o), 0);
      @(negedge clk_i);
      core_hold_i = 1'b0;
   endtask

   task automatic clear_done();
      clear_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
   endtask

   logic [511:0] exp1, exp2;
   int           base;

   initial begin
      // Reset state
      repeat (2) @(negedge clk_i);
      chk("rst_ready", 32'(s_ready_o), 0);
      chk("rst_en", 32'(core_en_o), 0);
      chk("rst_core_rst", 32'(core_rst_o), 1);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_done", 32'(done_o), 0);
      chkb("rst_blk", blk_o, '0);
      rst_i = 1'b0;

      // "abc": single block with 0x80 inside the partial word, length 24
      base = launches;
      send(32'h6162_6300, 1'b1, 2'd3);
      run_core();
      exp1 = put('0, 0, 32'h6162_6380);
      exp1 = put(exp1, 15, 32'h0000_0018);
      chk("abc_done", 32'(done_o), 1);
      chk("abc_busy", 32'(busy_o), 0);
      chk("abc_core_rst", 32'(core_rst_o), 0);
      chk("abc_launches", 32'(launches - base), 1);
      chkb("abc_blk", capat(base), exp1);
      repeat (3) @(negedge clk_i);
      chk("done_hold", 32'(done_o), 1);

      // clear_i together with s_valid_i: go IDLE, nothing accepted
      clear_i   = 1'b1;
      s_valid_i = 1'b1;
      s_data_i  = 32'hDEAD_BEEF;
      @(negedge clk_i);
      clear_i = 1'b0;
      chk("clr_core_rst", 32'(core_rst_o), 1);
      chk("clr_ready", 32'(s_ready_o), 0);
      chk("clr_done", 32'(done_o), 0);
      s_valid_i = 1'b0;

      // 56 bytes: marker lands in word 14, length spills to a second block
      base = launches;
      for (int unsigned i = 0; i < 14; i++) send(w(i), i == 13, 2'd0);
      run_core();
      run_core();
      exp1 = '0;
      for (int unsigned i = 0; i < 14; i++) exp1 = put(exp1, i, w(i));
      exp1 = put(exp1, 14, 32'h8000_0000);
      exp2 = put('0, 15, 32'h0000_01C0);
      chk("m56_launches", 32'(launches - base), 2);
      chkb("m56_blk0", capat(base), exp1);
      chkb("m56_blk1", capat(base + 1), exp2);
      chk("m56_done", 32'(done_o), 1);
      clear_done();

      // 18 words, valid held through LAUNCH/RUN of the intermediate block
      base = launches;
      for (int unsigned i = 0; i < 16; i++) send(w(i), 1'b0, 2'd0);
      s_data_i  = w(16);
      s_valid_i = 1'b1;
      run_core();
      send(w(16), 1'b0, 2'd0);
      send(32'hC0DE_0011, 1'b1, 2'd2);
      run_core();
      exp1 = '0;
      for (int unsigned i = 0; i < 16; i++) exp1 = put(exp1, i, w(i));
      exp2 = put('0, 0, w(16));
      exp2 = put(exp2, 1, 32'hC0DE_8000);
      exp2 = put(exp2, 15, 32'h0000_0230);
      chk("bp_launches", 32'(launches - base), 2);
      chkb("bp_blk0", capat(base), exp1);
      chkb("bp_blk1", capat(base + 1), exp2);
      chk("bp_done", 32'(done_o), 1);
      clear_done();

      // 64 bytes: data block, then marker-at-word-0 block with length 512
      base = launches;
      for (int unsigned i = 0; i < 16; i++) send(w(i), i == 15, 2'd0);
      run_core();
      run_core();
      exp1 = '0;
      for (int unsigned i = 0; i < 16; i++) exp1 = put(exp1, i, w(i));
      exp2 = put('0, 0, 32'h8000_0000);
      exp2 = put(exp2, 15, 32'h0000_0200);
      chk("m64_launches", 32'(launches - base), 2);
      chkb("m64_blk0", capat(base), exp1);
      chkb("m64_blk1", capat(base + 1), exp2);
      chk("m64_done", 32'(done_o), 1);
      clear_done();

      // Reset while the core is running, then a clean "abc"
      send(32'h6162_6300, 1'b1, 2'd3);
      wait_en();
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("mrst_core_rst", 32'(core_rst_o), 1);
      chk("mrst_en", 32'(core_en_o), 0);
      chk("mrst_busy", 32'(busy_o), 0);
      chk("mrst_ready", 32'(s_ready_o), 0);
      chkb("mrst_blk", blk_o, '0);
      base = launches;
      send(32'h6162_6300, 1'b1, 2'd3);
      run_core();
      exp1 = put('0, 0, 32'h6162_6380);
      exp1 = put(exp1, 15, 32'h0000_0018);
      chk("abc2_launches", 32'(launches - base), 1);
      chkb("abc2_blk", capat(base), exp1);
      chk("abc2_done", 32'(done_o), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
